dram_ctrl: RTL
==============

// Module: dram_ctrl
// PURPOSE
//  Sequences the off-chip DRAM port (CSn/RASn/CASn/WEn/A/D/Q/VALID) for one word-wide requester
//  (the AXI DRAM slave wrapper in top). Converts single-word read/write requests into ACT/READ/WRITE/PRE
//  command sequences with programmable timing; tracks the open row for page-hit shortcutting.
// PARAMETERS
//  T_RCD   5   idle cycles between ACT and READ/WRITE command
//  T_RP    5   idle cycles after PRE before next ACT
//  T_WR    2   idle cycles after WRITE before PRE or next command
//  CNT_W   4   width of the timing down-counter (must hold max(T_RCD,T_RP,T_WR))
// PORTS
//  clk         in   1   system clock (DRAM model shares it)
//  rst         in   1   synchronous active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   controller accepts request this cycle
//  req_addr    in   32  byte address; row=[22:12], col=[11:2]
//  req_wstrb   in   4   byte enables; 4'b0000 = read
//  req_wdata   in   32  write data
//  resp_valid  out  1   one-cycle pulse: request completed
//  resp_rdata  out  32  read data, valid with resp_valid (held until next read)
//  DRAM_CSn    out  1   chip select, active low
//  DRAM_RASn   out  1   row strobe, active low
//  DRAM_CASn   out  1   column strobe, active low
//  DRAM_WEn    out  4   per-byte write enable, active low
//  DRAM_A      out  11  row or column address
//  DRAM_D      out  32  write data
//  DRAM_Q      in   32  read data
//  DRAM_valid  in   1   DRAM_Q valid this cycle
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): CSn=1 RASn=1 CASn=1 WEn=4'hF A=0 D=0 req_ready=0 resp_valid=0
//    resp_rdata=0; state=IDLE; row_open=0; counter=0. Reset mid-operation aborts silently, no resp.
//  - All DRAM outputs registered; every command asserted for exactly one cycle, then NOP
//    (CSn=0 RASn=1 CASn=1 WEn=4'hF) while the counter runs down.
//  - Encodings: ACT RAS=0 CAS=1 WEn=F A=row; READ RAS=1 CAS=0 WEn=F A={1'b0,col};
//    WRITE RAS=1 CAS=0 WEn=~wstrb A={1'b0,col} D=wdata; PRE RAS=0 CAS=1 WEn=4'h0.
//  - req_ready=1 only in IDLE; transfer when req_valid&req_ready; request fields latched then.
//  - States: IDLE, PRE, PRE_W, ACT, ACT_W, RD, RD_W, WR, WR_W, DONE.
//    IDLE -> (hit) RD|WR ; (miss, row_open) PRE ; (miss, !row_open) ACT.
//    PRE -> PRE_W (T_RP cycles) -> ACT -> ACT_W (T_RCD cycles) -> RD|WR.
//    RD -> RD_W until DRAM_valid; capture DRAM_Q into resp_rdata -> DONE.
//    WR -> WR_W (T_WR cycles) -> DONE. DONE: resp_valid=1 one cycle -> IDLE.
//  - Hit = row_open && latched row == open_row. A parameter of 0 skips its wait state.
//  - req_wstrb any non-zero pattern is a write; partial strobes pass straight to WEn.
//  - DRAM_valid outside RD_W is ignored. No timeout: RD_W waits indefinitely.
//  - Counter loads T_x-1 on entering the wait state, exits when 0; no wrap.
// CONFIGURATION
//  DRAM_OPEN_PAGE_EN defined: row left open after access (row_open=1, open_row kept); hits skip
//    PRE/ACT. Not defined: closed page - after RD_W/WR_W go PRE -> PRE_W before DONE; row_open
//    always 0 in IDLE; every access issues ACT.
// TESTING
//  1 rst held 3 cycles mid-ACT_W -> all outputs at reset values next cycle, req_ready=1 after release.
//  2 cold read 0x0004_0000 (row 0x040, col 0), T_RCD=5, VALID 3 cycles after READ, Q=0xDEADBEEF
//    -> ACT A=0x040, 5 NOPs, READ A=0, resp_valid with rdata=0xDEADBEEF.
//  3 write wstrb=4'b0011 data 0x1234_5678 -> WRITE with WEn=4'b1100, D=0x12345678, resp after T_WR.
//  4 (OPEN_PAGE_EN) second access to same row -> no PRE/ACT, READ issued 1 cycle after accept.
//  5 (OPEN_PAGE_EN) access row 0x041 after 0x040 -> PRE, T_RP NOPs, ACT A=0x041, then column cmd.
//  6 req_valid held during busy -> req_ready=0 throughout, accepted only on return to IDLE.

Source files
------------

// File: rtl/dram_ctrl.sv
// Single-requester DRAM sequencer: turns word requests into ACT/READ/WRITE/PRE with programmable gaps.
// Define DRAM_OPEN_PAGE_EN to keep rows open between accesses; default build is closed page.
module dram_ctrl #(
  parameter int T_RCD = 5,
  parameter int T_RP  = 5,
  parameter int T_WR  = 2,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_PRE   = 4'd1;
  localparam logic [3:0] S_PRE_W = 4'd2;
  localparam logic [3:0] S_ACT   = 4'd3;
  localparam logic [3:0] S_ACT_W = 4'd4;
  localparam logic [3:0] S_RD    = 4'd5;
  localparam logic [3:0] S_RD_W  = 4'd6;
  localparam logic [3:0] S_WR    = 4'd7;
  localparam logic [3:0] S_WR_W  = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'((T_RCD > 0) ? T_RCD - 1 : 0);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'((T_RP  > 0) ? T_RP  - 1 : 0);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'((T_WR  > 0) ? T_WR  - 1 : 0);

`ifdef DRAM_OPEN_PAGE_EN
  localparam logic [3:0] S_FINISH = S_DONE;
`else
  localparam logic [3:0] S_FINISH = S_PRE;
`endif

  logic [3:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             row_open;
  logic [10:0]      open_row;
  logic [10:0]      lat_row;
  logic [9:0]       lat_col;
  logic [3:0]       lat_wstrb;
  logic [31:0]      lat_wdata;
  logic             access_done, done_nx;

  logic             accept;
  logic [10:0]      cur_row;
  logic [9:0]       cur_col;
  logic [3:0]       cur_wstrb;
  logic [31:0]      cur_wdata;
  logic [3:0]       col_st;
  logic [3:0]       after_pre;

  logic             cs_nx, ras_nx, cas_nx;
  logic [3:0]       wen_nx;
  logic [10:0]      a_nx;
  logic [31:0]      d_nx;

  logic             unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:23], req_addr[1:0]};

  // In IDLE the request fields are not latched yet, so commands issued on accept use them directly.
  always_comb begin
    accept    = req_valid && req_ready && (state == S_IDLE);
    cur_row   = (state == S_IDLE) ? req_addr[22:12] : lat_row;
    cur_col   = (state == S_IDLE) ? req_addr[11:2]  : lat_col;
    cur_wstrb = (state == S_IDLE) ? req_wstrb       : lat_wstrb;
    cur_wdata = (state == S_IDLE) ? req_wdata       : lat_wdata;
    col_st    = (cur_wstrb != 4'h0) ? S_WR : S_RD;
    after_pre = access_done ? S_DONE : S_ACT;
  end

  always_comb begin
    state_nx = state;
    done_nx  = access_done;
    case (state)
      S_IDLE: begin
        if (accept) begin
          done_nx = 1'b0;
          if (row_open && (req_addr[22:12] == open_row)) state_nx = col_st;
          else if (row_open)                             state_nx = S_PRE;
          else                                           state_nx = S_ACT;
        end
      end
      S_PRE:   state_nx = (T_RP == 0) ? after_pre : S_PRE_W;
      S_PRE_W: if (cnt == '0) state_nx = after_pre;
      S_ACT:   state_nx = (T_RCD == 0) ? col_st : S_ACT_W;
      S_ACT_W: if (cnt == '0) state_nx = col_st;
      S_RD:    state_nx = S_RD_W;
      S_RD_W: begin
        if (DRAM_valid) begin
          state_nx = S_FINISH;
          done_nx  = 1'b1;
        end
      end
      S_WR: begin
        state_nx = (T_WR == 0) ? S_FINISH : S_WR_W;
        done_nx  = 1'b1;
      end
      S_WR_W:  if (cnt == '0) state_nx = S_FINISH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The counter is loaded only on entry to a wait state and then runs down to zero and sticks.
  always_comb begin
    cnt_nx = cnt;
    if (state_nx == S_PRE_W && state != S_PRE_W)      cnt_nx = RP_LD;
    else if (state_nx == S_ACT_W && state != S_ACT_W) cnt_nx = RCD_LD;
    else if (state_nx == S_WR_W && state != S_WR_W)   cnt_nx = WR_LD;
    else if (cnt != '0)                               cnt_nx = cnt - CNT_W'(1);
  end

  // Commands are decoded from the next state so each appears exactly on the cycle its state is entered.
  always_comb begin
    cs_nx  = (state_nx == S_IDLE);
    ras_nx = 1'b1;
    cas_nx = 1'b1;
    wen_nx = 4'hF;
    a_nx   = DRAM_A;
    d_nx   = DRAM_D;
    case (state_nx)
      S_ACT: begin
        ras_nx = 1'b0;
        a_nx   = cur_row;
      end
      S_PRE: begin
        ras_nx = 1'b0;
        wen_nx = 4'h0;
      end
      S_RD: begin
        cas_nx = 1'b0;
        a_nx   = {1'b0, cur_col};
      end
      S_WR: begin
        cas_nx = 1'b0;
        wen_nx = ~cur_wstrb;
        a_nx   = {1'b0, cur_col};
        d_nx   = cur_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      row_open    <= 1'b0;
      open_row    <= '0;
      lat_row     <= '0;
      lat_col     <= '0;
      lat_wstrb   <= '0;
      lat_wdata   <= '0;
      access_done <= 1'b0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      DRAM_CSn    <= 1'b1;
      DRAM_RASn   <= 1'b1;
      DRAM_CASn   <= 1'b1;
      DRAM_WEn    <= 4'hF;
      DRAM_A      <= '0;
      DRAM_D      <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      access_done <= done_nx;
      req_ready   <= (state_nx == S_IDLE);
      resp_valid  <= (state_nx == S_DONE);
      DRAM_CSn    <= cs_nx;
      DRAM_RASn   <= ras_nx;
      DRAM_CASn   <= cas_nx;
      DRAM_WEn    <= wen_nx;
      DRAM_A      <= a_nx;
      DRAM_D      <= d_nx;
      if (accept) begin
        lat_row   <= req_addr[22:12];
        lat_col   <= req_addr[11:2];
        lat_wstrb <= req_wstrb;
        lat_wdata <= req_wdata;
      end
      if (state_nx == S_ACT) begin
        row_open <= 1'b1;
        open_row <= cur_row;
      end else if (state_nx == S_PRE) begin
        row_open <= 1'b0;
      end
      if (state == S_RD_W && DRAM_valid) resp_rdata <= DRAM_Q;
    end
  end

endmodule
